term_tile_cfg_loop: RTL and testbench

//  Parametrised fabric termination tile for array edges and corners. Loops NUM_WIRES incoming

---
 rtl/term_tile_cfg_loop.sv | 140 ++++++++++++++
 tb/tb_term_tile_cfg_loop.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/term_tile_cfg_loop.sv
// Fabric termination tile: per-wire configurable loopback (Nin -> Sout) set by captured config frames,
// plus a retimed frame bus. Optional activity counter enabled by TERM_ACTIVITY_CNT_EN.

module term_lb_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic       nin,
  input  logic [1:0] mode,
  output logic       sout
);
  logic lb_q;

  always_ff @(posedge clk) begin
    if (rst) lb_q <= 1'b0;
    else     lb_q <= nin;
  end

  // Reset forces the direct path so the edge stays transparent while config is being cleared.
  always_comb begin
    sout = nin;
    if (!rst) begin
      case (mode)
        2'b01:   sout = ~nin;
        2'b10:   sout = 1'b0;
        2'b11:   sout = lb_q;
        default: sout = nin;
      endcase
    end
  end
endmodule

module term_tile_cfg_loop #(
  parameter int NUM_WIRES          = 16,
  parameter int FRAME_BITS_PER_ROW = 32,
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int CFG_FRAMES         = 2,
  parameter int PIPE_STAGES        = 1
`ifdef TERM_ACTIVITY_CNT_EN
  , parameter int ACT_W            = 16
`endif
) (
  input  logic                          UserCLK,
  input  logic                          UserRST,
  input  logic [NUM_WIRES-1:0]          Nin,
  output logic [NUM_WIRES-1:0]          Sout,
  input  logic [FRAME_BITS_PER_ROW-1:0] FrameData,
  output logic [FRAME_BITS_PER_ROW-1:0] FrameData_O,
  input  logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe,
  output logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe_O,
  output logic                          UserCLKo
`ifdef TERM_ACTIVITY_CNT_EN
  , output logic [ACT_W-1:0]            ActCnt
`endif
);
  localparam int CFG_W = CFG_FRAMES * FRAME_BITS_PER_ROW;

  if (2 * NUM_WIRES > CFG_W) begin : g_err_cfg_w
    $error("term_tile_cfg_loop: config frames too small for NUM_WIRES");
  end
  if (CFG_FRAMES > MAX_FRAMES_PER_COL) begin : g_err_frames
    $error("term_tile_cfg_loop: CFG_FRAMES exceeds MAX_FRAMES_PER_COL");
  end
  if (PIPE_STAGES > 4 || PIPE_STAGES < 0) begin : g_err_pipe
    $error("term_tile_cfg_loop: PIPE_STAGES out of range 0..4");
  end

  typedef struct packed {
    logic [FRAME_BITS_PER_ROW-1:0] data;
    logic [MAX_FRAMES_PER_COL-1:0] strobe;
  } fbus_t;

  // Packed so the flat view is {frame[CFG_FRAMES-1], ..., frame[0]}.
  logic [CFG_FRAMES-1:0][FRAME_BITS_PER_ROW-1:0] cfg_frame;
  logic [CFG_W-1:0]                              cfg_flat;

  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      cfg_frame <= '0;
    end else begin
      for (int f = 0; f < CFG_FRAMES; f++)
        if (FrameStrobe[f]) cfg_frame[f] <= FrameData;
    end
  end

  assign cfg_flat = cfg_frame;

  if (CFG_W > 2 * NUM_WIRES) begin : g_cfg_spare
    logic unused_cfg;
    assign unused_cfg = ^cfg_flat[CFG_W-1:2*NUM_WIRES];
  end

  for (genvar i = 0; i < NUM_WIRES; i++) begin : g_lane
    term_lb_cell u_cell (
      .clk  (UserCLK),
      .rst  (UserRST),
      .nin  (Nin[i]),
      .mode (cfg_flat[2*i +: 2]),
      .sout (Sout[i])
    );
  end

  fbus_t fbus_in;
  assign fbus_in = '{data: FrameData, strobe: FrameStrobe};

  if (PIPE_STAGES == 0) begin : g_pipe_none
    assign FrameData_O   = fbus_in.data;
    assign FrameStrobe_O = fbus_in.strobe;
  end else begin : g_pipe
    fbus_t [PIPE_STAGES-1:0] pipe;

    always_ff @(posedge UserCLK) begin
      if (UserRST) begin
        pipe <= '0;
      end else begin
        pipe[0] <= fbus_in;
        for (int s = 1; s < PIPE_STAGES; s++) pipe[s] <= pipe[s-1];
      end
    end

    assign FrameData_O   = pipe[PIPE_STAGES-1].data;
    assign FrameStrobe_O = pipe[PIPE_STAGES-1].strobe;
  end

  // Stands in for the technology clock buffer; never gated or reset.
  assign UserCLKo = UserCLK;

`ifdef TERM_ACTIVITY_CNT_EN
  logic [NUM_WIRES-1:0] nin_q;

  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      nin_q  <= '0;
      ActCnt <= '0;
    end else begin
      nin_q <= Nin;
      if (Nin != nin_q && ActCnt != {ACT_W{1'b1}}) ActCnt <= ActCnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_term_tile_cfg_loop.sv
// Randomized + directed bench for term_tile_cfg_loop against a frame/mode-level reference model.
// Three instances share stimulus: PIPE_STAGES = 1 (default), 2 and 0.

module tb_term_tile_cfg_loop;
  localparam int TB_ACT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] nin;
  logic [31:0] fd;
  logic [19:0] fs;

  logic [15:0] sout1, sout2, sout0;
  logic [31:0] fdo1, fdo2, fdo0;
  logic [19:0] fso1, fso2, fso0;
  logic        ck1, ck2, ck0;
`ifdef TERM_ACTIVITY_CNT_EN
  logic [TB_ACT_W-1:0] act1, act2, act0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  term_tile_cfg_loop #(.PIPE_STAGES(1)
`ifdef TERM_ACTIVITY_CNT_EN
    , .ACT_W(TB_ACT_W)
`endif
  ) dut (
    .UserCLK(clk), .UserRST(rst), .Nin(nin), .Sout(sout1),
    .FrameData(fd), .FrameData_O(fdo1), .FrameStrobe(fs), .FrameStrobe_O(fso1),
    .UserCLKo(ck1)
`ifdef TERM_ACTIVITY_CNT_EN
    , .ActCnt(act1)
`endif
  );

  term_tile_cfg_loop #(.PIPE_STAGES(2)
`ifdef TERM_ACTIVITY_CNT_EN
    , .ACT_W(TB_ACT_W)
`endif
  ) dut2 (
    .UserCLK(clk), .UserRST(rst), .Nin(nin), .Sout(sout2),
    .FrameData(fd), .FrameData_O(fdo2), .FrameStrobe(fs), .FrameStrobe_O(fso2),
    .UserCLKo(ck2)
`ifdef TERM_ACTIVITY_CNT_EN
    , .ActCnt(act2)
`endif
  );

  term_tile_cfg_loop #(.PIPE_STAGES(0)
`ifdef TERM_ACTIVITY_CNT_EN
    , .ACT_W(TB_ACT_W)
`endif
  ) dut0 (
    .UserCLK(clk), .UserRST(rst), .Nin(nin), .Sout(sout0),
    .FrameData(fd), .FrameData_O(fdo0), .FrameStrobe(fs), .FrameStrobe_O(fso0),
    .UserCLKo(ck0)
`ifdef TERM_ACTIVITY_CNT_EN
    , .ActCnt(act0)
`endif
  );

  // Reference model state
  logic [31:0] m_cfg [2];
  logic [15:0] m_lb;
  logic [31:0] hd[$];
  logic [19:0] hs[$];
  logic [15:0] m_ninq;
  int          m_act;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_sout();
    logic [63:0] flat;
    logic [15:0] r;
    int md;
    flat = {m_cfg[1], m_cfg[0]};
    for (int i = 0; i < 16; i++) begin
      md = rst ? 0 : int'(flat[2*i +: 2]);
      case (md)
        0: r[i] = nin[i];
        1: r[i] = ~nin[i];
        2: r[i] = 1'b0;
        default: r[i] = m_lb[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_fd(int p);
    return (p == 0) ? fd : hd[p-1];
  endfunction

  function automatic logic [19:0] exp_fs(int p);
    return (p == 0) ? fs : hs[p-1];
  endfunction

  task automatic model_reset();
    m_cfg[0] = '0; m_cfg[1] = '0; m_lb = '0; m_ninq = '0; m_act = 0;
    hd = '{0, 0, 0, 0};
    hs = '{0, 0, 0, 0};
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (fs[0]) m_cfg[0] = fd;
      if (fs[1]) m_cfg[1] = fd;
      m_lb = nin;
      hd.push_front(fd); void'(hd.pop_back());
      hs.push_front(fs); void'(hs.pop_back());
      if (nin != m_ninq && m_act < (1 << TB_ACT_W) - 1) m_act++;
      m_ninq = nin;
    end
  endtask

  // Apply inputs after the falling edge, check combinational view, then advance one clock.
  task automatic step(input logic r, input logic [15:0] n, input logic [31:0] d, input logic [19:0] s);
    rst = r; nin = n; fd = d; fs = s;
    #1;
    chk("sout_p1", sout1, exp_sout());
    chk("sout_p2", sout2, exp_sout());
    chk("sout_p0", sout0, exp_sout());
    chk("fdo_p1", fdo1, exp_fd(1));
    chk("fso_p1", fso1, exp_fs(1));
    chk("fdo_p2", fdo2, exp_fd(2));
    chk("fso_p2", fso2, exp_fs(2));
    chk("fdo_p0", fdo0, exp_fd(0));
    chk("fso_p0", fso0, exp_fs(0));
`ifdef TERM_ACTIVITY_CNT_EN
    chk("actcnt", act1, m_act);
`endif
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; nin = '0; fd = '0; fs = '0;
    model_reset();
    @(negedge clk);
    step(1, 16'h0, 32'h0, 20'h0);
    step(1, 16'h0, 32'h0, 20'h0);
    chk("rst_fso", fso1, 20'h0);
    chk("rst_fdo", fdo1, 32'h0);
    chk("clk_buf", ck1, clk);

    // T1: direct loopback after reset
    step(0, 16'hA5C3, 32'h0, 20'h0);
    chk("t1_sout", sout1, 16'hA5C3);
    chk("t1_fso", fso1, 20'h0);

    // T2: all wires invert
    step(0, 16'h0, 32'h5555_5555, 20'h1);
    step(0, 16'h00FF, 32'h0, 20'h0);
    chk("t2_sout", sout1, 16'hFF00);

    // T3: registered loopback latency
    step(0, 16'h0, 32'hFFFF_FFFF, 20'h1);
    step(0, 16'h0, 32'h0, 20'h0);
    nin = 16'h1234;
    #1 chk("t3_same", sout1, 16'h0);
    @(negedge clk);
    model_edge();
    step(0, 16'h1234, 32'h0, 20'h0);
    chk("t3_next", sout1, 16'h1234);

    // T4: reset beats strobe, then tie-0 takes effect
    step(1, 16'h1234, 32'hAAAA_AAAA, 20'h3);
    chk("t4_rst", sout1, 16'h1234);
    step(0, 16'h1234, 32'hAAAA_AAAA, 20'h3);
    chk("t4_tie0", sout1, 16'h0);

    // T5: frame bus delay on the 2-stage instance
    step(1, 16'h0, 32'h0, 20'h0);
    step(0, 16'h0, 32'hDEAD_BEEF, 20'h80001);
    chk("t5_d1_fdo", fdo2, 32'h0);
    step(0, 16'h0, 32'h0, 20'h0);
    chk("t5_d2_fdo", fdo2, 32'hDEAD_BEEF);
    chk("t5_d2_fso", fso2, 20'h80001);
    step(0, 16'h0, 32'h0, 20'h0);
    chk("t5_d3_fso", fso2, 20'h0);

    // Reset mid-pipeline drops in-flight words
    step(0, 16'h0, 32'h1357_9BDF, 20'h4);
    step(1, 16'h0, 32'h0, 20'h0);
    chk("midrst_fso", fso2, 20'h0);

    // Random phase
    for (int c = 0; c < 400; c++) begin
      logic        r;
      logic [19:0] s;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0;
      step(r, 16'($urandom), $urandom, s);
    end

`ifdef TERM_ACTIVITY_CNT_EN
    // T6: saturating activity counter
    step(1, 16'h0, 32'h0, 20'h0);
    for (int c = 0; c < 20; c++) step(0, {15'h0, c[0] ^ 1'b1}, 32'h0, 20'h0);
    chk("t6_sat", act1, 4'hF);
    step(1, 16'h0, 32'h0, 20'h0);
    chk("t6_clr", act1, 4'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
